// File: rtl/sync_fifo_wr_arb_pkg.sv
// fifo_arb_pkg: shared types and default sizing for the FIFO write arbiter.
// The arbiter state encoding lives here so that the top and any future
// monitor agree on it.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FIFO_DEPTH    = 8;
    localparam int FIFO_CNT_W    = 4;
    localparam int FIFO_DATA_W   = 8;
    localparam int ARB_NUM_REQ   = 4;
    localparam int ARB_BURST_LEN = 4;

    // Index width for n producers; never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arb_if.sv
// sync_fifo_wr_arb_if: producer-side handshake plus FIFO write port.
// master = producers/FIFO environment, slave = the arbiter.
interface sync_fifo_wr_arb_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int DATA_W  = FIFO_DATA_W,
    parameter int CNT_W   = FIFO_CNT_W
);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [CNT_W-1:0]          fifo_cnt;
    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_din;
    logic [IDX_W-1:0]          grant_id;
    logic                      arb_busy;

    modport master (
        output req_valid, req_data, fifo_cnt,
        input  req_ready, fifo_wr, fifo_din, grant_id, arb_busy
    );

    modport slave (
        input  req_valid, req_data, fifo_cnt,
        output req_ready, fifo_wr, fifo_din, grant_id, arb_busy
    );

endinterface

// File: rtl/sync_fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches last+1, last+2, ...
// modulo NUM_REQ and returns the first requester found, as one-hot and index.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi+1 places after the last winner.
    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = IDX_W'((32'(last) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    // Lowest search distance wins; scanning downward lets it overwrite the rest.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_idx = cand_idx[k];
                found     = 1'b1;
            end
        end
        grant_oh = found ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers, with a registered write stage and an overflow-safe
// admission check that counts the write already in flight.
// Optional burst-lock mode: define FIFO_ARB_BURST_EN.
module sync_fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = ARB_NUM_REQ,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int CNT_W     = FIFO_CNT_W,
    parameter int BURST_LEN = ARB_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_wr_arb_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_REQ);

    // An out-of-range configuration never admits a beat, so a bad parameter
    // shows up as a stalled arbiter instead of FIFO corruption.
    localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) &&
                            (BURST_LEN >= 1) && (BURST_LEN <= 15) &&
                            (DEPTH < (1 << CNT_W));

    logic                 fifo_wr_reg;
    logic [DATA_W-1:0]    fifo_din_reg;
    logic [IDX_W-1:0]     grant_id_reg;
    logic [IDX_W-1:0]     last_reg;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;

    logic [CNT_W:0]       occ;
    logic                 space;
    logic [NUM_REQ-1:0]   ready;
    logic [IDX_W-1:0]     src_idx;
    logic                 xfer;
    logic [DATA_W-1:0]    beat [NUM_REQ];

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_beat
        assign beat[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (bus.req_valid),
        .last      (last_reg),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .found     (pick_found)
    );

    // The registered write counts as occupied: it lands in the FIFO this cycle.
    assign occ   = {1'b0, bus.fifo_cnt} + {{CNT_W{1'b0}}, fifo_wr_reg};
    assign space = CFG_OK && (occ < (CNT_W+1)'(DEPTH));
    assign xfer  = |(bus.req_valid & ready);

`ifdef FIFO_ARB_BURST_EN
    localparam int BEAT_W = 4;

    arb_state_t           state_reg;
    logic [IDX_W-1:0]     owner_reg;
    logic [BEAT_W-1:0]    beats_reg;
    logic                 arb_busy_reg;

    // Ready selection: fresh round-robin in ARB, only the owner in BURST.
    always_comb begin
        ready   = '0;
        src_idx = pick_idx;
        if (state_reg == BURST) begin
            src_idx = owner_reg;
            if (space && bus.req_valid[owner_reg]) begin
                ready[owner_reg] = 1'b1;
            end
        end else if (space && pick_found) begin
            ready = pick_oh;
        end
    end

    // Burst-lock FSM; arb_busy is registered alongside the state it mirrors.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB;
            owner_reg    <= '0;
            beats_reg    <= '0;
            arb_busy_reg <= 1'b0;
        end else begin
            case (state_reg)
                ARB: begin
                    if (xfer && (BURST_LEN > 1)) begin
                        state_reg    <= BURST;
                        owner_reg    <= src_idx;
                        beats_reg    <= BEAT_W'(1);
                        arb_busy_reg <= 1'b1;
                    end
                end
                BURST: begin
                    if (!bus.req_valid[owner_reg]) begin
                        state_reg    <= ARB;
                        arb_busy_reg <= 1'b0;
                    end else if (xfer) begin
                        beats_reg <= beats_reg + BEAT_W'(1);
                        if (beats_reg == BEAT_W'(BURST_LEN - 1)) begin
                            state_reg    <= ARB;
                            arb_busy_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg    <= ARB;
                    arb_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arb_busy = arb_busy_reg;
`else
    // Ready selection: fresh round-robin every beat.
    always_comb begin
        ready   = '0;
        src_idx = pick_idx;
        if (space && pick_found) begin
            ready = pick_oh;
        end
    end

    assign bus.arb_busy = 1'b0;
`endif

    // Registered write stage; data and source hold when no beat transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_reg  <= 1'b0;
            fifo_din_reg <= '0;
            grant_id_reg <= '0;
            last_reg     <= IDX_W'(NUM_REQ - 1);
        end else begin
            fifo_wr_reg <= xfer;
            if (xfer) begin
                fifo_din_reg <= beat[src_idx];
                grant_id_reg <= src_idx;
                last_reg     <= src_idx;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.fifo_wr   = fifo_wr_reg;
    assign bus.fifo_din  = fifo_din_reg;
    assign bus.grant_id  = grant_id_reg;

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// tb_sync_fifo_wr_arb: vector table, reset sequence and randomized run
// against a queue-free behavioural model of the arbitration rules.
// Builds with or without FIFO_ARB_BURST_EN.
module tb_sync_fifo_wr_arb;
    import fifo_arb_pkg::*;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int CW  = 4;
    localparam int BL  = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_wr_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW)) bus ();

    sync_fifo_wr_arb #(
        .NUM_REQ(NR), .DATA_W(DW), .DEPTH(DEP), .CNT_W(CW), .BURST_LEN(BL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] valid;
        logic [3:0] cnt;
        logic [3:0] exp_ready;
        logic       exp_wr;
        logic [7:0] exp_din;
        logic [1:0] exp_gid;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [16];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    // One cycle: drive, check combinational ready mid-cycle, then registered outputs.
    task automatic cyc(input string tag, input vec_t v);
        bus.req_valid = v.valid;
        bus.fifo_cnt  = v.cnt;
        #3;
        check({tag, ".ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        check({tag, ".wr"},   32'(bus.fifo_wr),  32'(v.exp_wr));
        check({tag, ".din"},  32'(bus.fifo_din), 32'(v.exp_din));
        check({tag, ".gid"},  32'(bus.grant_id), 32'(v.exp_gid));
        check({tag, ".busy"}, 32'(bus.arb_busy), 32'(v.exp_busy));
        $display("vec %s valid=%b cnt=%0d wr=%b din=%h gid=%0d busy=%b",
                 tag, v.valid, v.cnt, bus.fifo_wr, bus.fifo_din, bus.grant_id, bus.arb_busy);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.fifo_cnt  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Behavioural reference state.
    int         m_last;
    bit         m_wr;
    int         m_lock;
    int         m_run;
    logic [7:0] m_din;
    int         m_gid;

    initial begin
        logic [7:0] rd [NR];
        logic [3:0] v;
        int         cnt;
        int         win;
        int         j;
        bit         space;
        logic [3:0] exp_ready;

`ifdef FIFO_ARB_BURST_EN
        tbl[0]  = '{4'b1010, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
        tbl[1]  = '{4'b1010, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
        tbl[2]  = '{4'b1010, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
        tbl[3]  = '{4'b1010, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0};
        tbl[4]  = '{4'b1010, 4'd0, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1};
        tbl[5]  = '{4'b0000, 4'd0, 4'b0000, 1'b0, 8'hA3, 2'd3, 1'b0};
        tbl[6]  = '{4'b0011, 4'd0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
        tbl[7]  = '{4'b0011, 4'd0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
        tbl[8]  = '{4'b0010, 4'd0, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b0};
        tbl[9]  = '{4'b0010, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
        tbl[10] = '{4'b0010, 4'd7, 4'b0000, 1'b0, 8'hA1, 2'd1, 1'b1};
        tbl[11] = '{4'b0010, 4'd6, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
        tbl[12] = '{4'b0010, 4'd8, 4'b0000, 1'b0, 8'hA1, 2'd1, 1'b1};
        tbl[13] = '{4'b1111, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
        tbl[14] = '{4'b1111, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0};
        tbl[15] = '{4'b1111, 4'd0, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1};
`else
        tbl[0]  = '{4'b1111, 4'd0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0};
        tbl[1]  = '{4'b1111, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0};
        tbl[2]  = '{4'b1111, 4'd0, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0};
        tbl[3]  = '{4'b1111, 4'd0, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b0};
        tbl[4]  = '{4'b0000, 4'd0, 4'b0000, 1'b0, 8'hA3, 2'd3, 1'b0};
        tbl[5]  = '{4'b0100, 4'd7, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0};
        tbl[6]  = '{4'b0100, 4'd7, 4'b0000, 1'b0, 8'hA2, 2'd2, 1'b0};
        tbl[7]  = '{4'b0100, 4'd8, 4'b0000, 1'b0, 8'hA2, 2'd2, 1'b0};
        tbl[8]  = '{4'b1111, 4'd8, 4'b0000, 1'b0, 8'hA2, 2'd2, 1'b0};
        tbl[9]  = '{4'b1011, 4'd8, 4'b0000, 1'b0, 8'hA2, 2'd2, 1'b0};
        tbl[10] = '{4'b1111, 4'd6, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b0};
        tbl[11] = '{4'b1111, 4'd6, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0};
        tbl[12] = '{4'b1111, 4'd7, 4'b0000, 1'b0, 8'hA0, 2'd0, 1'b0};
        tbl[13] = '{4'b0110, 4'd0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b0};
        tbl[14] = '{4'b0101, 4'd0, 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b0};
        tbl[15] = '{4'b0011, 4'd0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0};
`endif

        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        do_reset();
        check("reset.wr",   32'(bus.fifo_wr),  32'd0);
        check("reset.din",  32'(bus.fifo_din), 32'd0);
        check("reset.gid",  32'(bus.grant_id), 32'd0);
        check("reset.busy", 32'(bus.arb_busy), 32'd0);
        #3;
        check("reset.ready_idle", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i]);
        end

        // Reset while (in burst builds) a burst is running: nothing replays.
        bus.req_valid = 4'b1111;
        bus.fifo_cnt  = 4'd0;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.wr",   32'(bus.fifo_wr),  32'd0);
        check("midrst.busy", 32'(bus.arb_busy), 32'd0);
        check("midrst.din",  32'(bus.fifo_din), 32'd0);
        cyc("midrst.first", '{4'b1111, 4'd0, 4'b0001, 1'b1, 8'hA0, 2'd0, BURST_ON});

        // Randomized run against the behavioural model.
        do_reset();
        m_last = NR - 1;
        m_wr   = 1'b0;
        m_lock = -1;
        m_run  = 0;
        m_din  = 8'h00;
        m_gid  = 0;
        for (int c = 0; c < 300; c++) begin
            v   = 4'($urandom_range(0, 15));
            cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8))
                                             : int'($urandom_range(5, 8));
            for (int i = 0; i < NR; i++) begin
                rd[i] = 8'($urandom);
                bus.req_data[i*DW +: DW] = rd[i];
            end
            bus.req_valid = v;
            bus.fifo_cnt  = 4'(cnt);

            space = (cnt + int'(m_wr)) < DEP;
            win   = -1;
            if (m_lock >= 0) begin
                if (v[m_lock] && space) win = m_lock;
            end else if (space) begin
                for (int k = 1; k <= NR; k++) begin
                    j = (m_last + k) % NR;
                    if (win < 0 && v[j]) win = j;
                end
            end
            exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0000;

            if (m_lock >= 0 && !v[m_lock]) m_lock = -1;
            if (win >= 0) begin
                m_last = win;
                m_din  = rd[win];
                m_gid  = win;
                if (BURST_ON) begin
                    if (m_lock < 0) begin
                        if (BL > 1) begin
                            m_lock = win;
                            m_run  = 1;
                        end
                    end else begin
                        m_run++;
                        if (m_run == BL) m_lock = -1;
                    end
                end
            end
            m_wr = (win >= 0);

            #3;
            check($sformatf("rnd%0d.ready", c), 32'(bus.req_ready), 32'(exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d.wr", c),   32'(bus.fifo_wr),  32'(m_wr));
            check($sformatf("rnd%0d.din", c),  32'(bus.fifo_din), 32'(m_din));
            check($sformatf("rnd%0d.gid", c),  32'(bus.grant_id), 32'(m_gid));
            check($sformatf("rnd%0d.busy", c), 32'(bus.arb_busy), 32'(m_lock >= 0));
            $display("rnd %0d valid=%b cnt=%0d win=%0d wr=%b din=%h gid=%0d",
                     c, v, cnt, win, bus.fifo_wr, bus.fifo_din, bus.grant_id);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
